ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-port arbiter that shares one single-port synchronous RAM (`sync_ram`, one-cycle registered access) between the CPU data port (port A) and the SPI programming port (port B). It replaces the static MODE multiplexer in front of the data RAM:
- Port B gets exclusive access in programming mode.
- The CPU has priority in run mode, with bounded-starvation service for SPI accesses.

All accesses are sequenced through a 4-state FSM with a req/ack handshake per port.

## Interface
Parameters:
- `DATA_WIDTH`, 16, RAM word width
- `ADD_WIDTH`, 6, RAM address width (64 words)
- `STARVE_MAX`, 4, consecutive A grants allowed while B is pending before B is forced (1..15)

Ports:
- `clk`  in  1  single clock; all state changes on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `mode`  in  1  1 = run (A priority), 0 = program (only B eligible)
- `a_req`, `a_we`  in  1  port A request / write enable
- `a_add`  in  ADD_WIDTH  port A address
- `a_din`  in  DATA_WIDTH  port A write data
- `a_ack`  out  1  port A one-cycle completion pulse
- `a_dout`  out  DATA_WIDTH  port A read data, valid while `a_ack`=1, held until next A completion
- `b_req`, `b_we`, `b_add`, `b_din`, `b_ack`, `b_dout`: same as A, for port B
- `mem_we`  out  1  RAM write enable (registered)
- `mem_add`  out  ADD_WIDTH  RAM address (registered)
- `mem_din`  out  DATA_WIDTH  RAM write data (registered)
- `mem_dout`  in  DATA_WIDTH  RAM read data
- `busy`  out  1  FSM not in IDLE
- `gnt_b`  out  1  current/last grant owner (0 = A, 1 = B)

## Operation
- FSM states: IDLE, ISSUE, CAPT, ACK.
- **IDLE → ISSUE:** taken when any eligible request is high.
  - Register `mem_add`, `mem_din`, `mem_we` from the winner; `mem_we` = winner's we.
  - Set `gnt_b`.
- **ISSUE → CAPT:** unconditional. RAM performs the access at this edge. `mem_we` clears.
- **CAPT → ACK:** unconditional.
  - Latch `mem_dout` into the winner's dout register (for writes, the RAM's read-during-write value).
  - Assert winner's ack.
- **ACK → IDLE:** unconditional. Ack deasserts.
- **Eligibility:**
  - `mode`=0: only B is eligible; A requests wait without ack.
  - `mode`=1: both ports are eligible.
  - A port whose ack is high in the current cycle is ineligible at that cycle's closing edge, so the requester has one cycle to drop req.
- **Priority (`mode`=1):** A wins, except when B is pending and `starve_cnt` = `STARVE_MAX`, in which case B wins.
- **`starve_cnt` (4 bits):**
  - Increments on each A grant while `b_req`=1.
  - Clears on a B grant, or on any IDLE cycle with `b_req`=0.
  - Saturates at `STARVE_MAX`.
- **Requester rule:** hold req, we, add and din stable from req assertion until ack; drop req in the ack cycle or later. Payload is sampled only at the IDLE→ISSUE edge.
- **Mode changes:** a `mode` change during ISSUE/CAPT/ACK does not abort the in-flight access. The new mode applies at the next IDLE arbitration.
- **Writes:** a write is committed at the ISSUE→CAPT edge only.

## Timing
- **Reset:**
  - Immediate: FSM=IDLE, `starve_cnt`=0.
  - Outputs: `mem_we`=0, `mem_add`=0, `mem_din`=0, `a_ack`=`b_ack`=0, `a_dout`=`b_dout`=0, `busy`=0, `gnt_b`=0.
  - Reset during ISSUE clears `mem_we` asynchronously. No write occurs unless the RAM edge already passed.
  - No ack is issued for the abandoned access; the requester must re-request.
- **Latency:** req sampled at edge E0 → `mem_*` valid E0..E1 → ack high for the cycle after E2.
  - 3 cycles req-to-ack when the arbiter is idle.
- **Throughput:** one access per 4 cycles. Back-to-back accesses grant at the edge ending ACK+1.
- **Simultaneous requests (`mode`=1, counter < `STARVE_MAX`):** A first. B is granted in IDLE after A's ACK if A has dropped req.
- **Simultaneous requests (counter at max):** B first.
- `busy` is high exactly in ISSUE, CAPT and ACK.

## Test plan
- Reset, then `mode`=1, A write `a_add`=5, `a_din`=16'hBEEF → `mem_we`=1 for exactly one cycle with add 5, `a_ack` 3 cycles after req. A read of 5 → `a_dout`=16'hBEEF with `a_ack`.
- `mode`=0, A and B both request (B read add 5) → only `b_ack` pulses, `b_dout`=16'hBEEF. `a_ack` stays 0 until `mode`=1, then A is served.
- `mode`=1, A requests continuously (re-asserting after each ack), B requests continuously, `STARVE_MAX`=4 → grant sequence A,A,A,A,B,A,A,A,A,B; `gnt_b` matches.
- Simultaneous A/B requests with counter 0 → A acked first, B acked exactly 4 cycles later. Req held one cycle into ack → no duplicate access.
- Assert `rst` in ISSUE of a write to add 9 (before the RAM edge) → all outputs 0 immediately, no ack, RAM location 9 unchanged on readback.
- Toggle `mode` 1→0 during CAPT of an A read → A access completes with `a_ack`; subsequent A request is not granted.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port synchronous RAM between the CPU data
// port (A) and the SPI programming port (B). Every access walks a fixed
// IDLE -> ISSUE -> CAPT -> ACK sequence. In run mode A has priority, and a
// starvation counter forces B through after STARVE_MAX consecutive A grants.
module ram_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADD_WIDTH  = 6,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADD_WIDTH-1:0]  a_add,
  input  logic [DATA_WIDTH-1:0] a_din,
  output logic                  a_ack,
  output logic [DATA_WIDTH-1:0] a_dout,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADD_WIDTH-1:0]  b_add,
  input  logic [DATA_WIDTH-1:0] b_din,
  output logic                  b_ack,
  output logic [DATA_WIDTH-1:0] b_dout,
  output logic                  mem_we,
  output logic [ADD_WIDTH-1:0]  mem_add,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  busy,
  output logic                  gnt_b
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPT, ACK} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t                state_q, state_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADD_WIDTH-1:0]  mem_add_q, mem_add_d;
  logic [DATA_WIDTH-1:0] mem_din_q, mem_din_d;
  logic                  a_ack_q, a_ack_d;
  logic                  b_ack_q, b_ack_d;
  logic [DATA_WIDTH-1:0] a_dout_q, a_dout_d;
  logic [DATA_WIDTH-1:0] b_dout_q, b_dout_d;
  logic                  gnt_b_q, gnt_b_d;
  logic [3:0]            starve_q, starve_d;

  logic elig_a, elig_b, pick_b;

  // Arbitration and sequencing: next-state and next-output computation.
  always_comb begin
    state_d   = state_q;
    mem_we_d  = mem_we_q;
    mem_add_d = mem_add_q;
    mem_din_d = mem_din_q;
    a_ack_d   = a_ack_q;
    b_ack_d   = b_ack_q;
    a_dout_d  = a_dout_q;
    b_dout_d  = b_dout_q;
    gnt_b_d   = gnt_b_q;
    starve_d  = starve_q;

    // A port being acked this cycle is not eligible, giving it a cycle to drop req.
    elig_a = mode & a_req & ~a_ack_q;
    elig_b = b_req & ~b_ack_q;
    pick_b = elig_b & (~elig_a | (starve_q == STARVE_LIM));

    unique case (state_q)
      IDLE: begin
        if (elig_a || elig_b) begin
          state_d   = ISSUE;
          gnt_b_d   = pick_b;
          mem_we_d  = pick_b ? b_we  : a_we;
          mem_add_d = pick_b ? b_add : a_add;
          mem_din_d = pick_b ? b_din : a_din;
          if (pick_b || !b_req)          starve_d = 4'd0;
          else if (starve_q < STARVE_LIM) starve_d = starve_q + 4'd1;
        end else if (!b_req) begin
          starve_d = 4'd0;
        end
      end
      ISSUE: begin
        // RAM samples the access at this edge; the write must not repeat.
        state_d  = CAPT;
        mem_we_d = 1'b0;
      end
      CAPT: begin
        state_d = ACK;
        if (gnt_b_q) begin
          b_dout_d = mem_dout;
          b_ack_d  = 1'b1;
        end else begin
          a_dout_d = mem_dout;
          a_ack_d  = 1'b1;
        end
      end
      ACK: begin
        state_d = IDLE;
        a_ack_d = 1'b0;
        b_ack_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any in-flight access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mem_we_q  <= 1'b0;
      mem_add_q <= '0;
      mem_din_q <= '0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      a_dout_q  <= '0;
      b_dout_q  <= '0;
      gnt_b_q   <= 1'b0;
      starve_q  <= 4'd0;
    end else begin
      state_q   <= state_d;
      mem_we_q  <= mem_we_d;
      mem_add_q <= mem_add_d;
      mem_din_q <= mem_din_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      a_dout_q  <= a_dout_d;
      b_dout_q  <= b_dout_d;
      gnt_b_q   <= gnt_b_d;
      starve_q  <= starve_d;
    end
  end

  assign mem_we  = mem_we_q;
  assign mem_add = mem_add_q;
  assign mem_din = mem_din_q;
  assign a_ack   = a_ack_q;
  assign b_ack   = b_ack_q;
  assign a_dout  = a_dout_q;
  assign b_dout  = b_dout_q;
  assign gnt_b   = gnt_b_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural one-cycle sync RAM.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mode = 1'b1;
  logic        a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [5:0]  a_add = '0, b_add = '0;
  logic [15:0] a_din = '0, b_din = '0;
  logic        a_ack, b_ack, mem_we, busy, gnt_b;
  logic [15:0] a_dout, b_dout, mem_din;
  logic [15:0] mem_dout = '0;
  logic [5:0]  mem_add;

  logic [15:0] ram [64];

  int checks = 0;
  int failures = 0;

  ram_arbiter #(.DATA_WIDTH(16), .ADD_WIDTH(6), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst), .mode(mode),
    .a_req(a_req), .a_we(a_we), .a_add(a_add), .a_din(a_din),
    .a_ack(a_ack), .a_dout(a_dout),
    .b_req(b_req), .b_we(b_we), .b_add(b_add), .b_din(b_din),
    .b_ack(b_ack), .b_dout(b_dout),
    .mem_we(mem_we), .mem_add(mem_add), .mem_din(mem_din), .mem_dout(mem_dout),
    .busy(busy), .gnt_b(gnt_b)
  );

  always #5 clk = ~clk;

  // Read-first single-port RAM
  always @(posedge clk) begin
    if (mem_we) ram[mem_add] <= mem_din;
    mem_dout <= ram[mem_add];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_acc(input bit pb, input bit we, input logic [5:0] add,
                        input logic [15:0] din, output int lat, output logic [15:0] dout);
    lat  = -1;
    dout = '0;
    if (pb) begin b_req = 1; b_we = we; b_add = add; b_din = din; end
    else    begin a_req = 1; a_we = we; a_add = add; a_din = din; end
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (pb ? b_ack : a_ack) begin
        lat  = i;
        dout = pb ? b_dout : a_dout;
        break;
      end
    end
    if (pb) b_req = 0; else a_req = 0;
    tick();
  endtask

  initial begin
    int lat, alat, blat, acnt, n;
    logic [15:0] d;
    logic a_seen;
    logic [9:0] seq, gseq;

    for (int i = 0; i < 64; i++) ram[i] = 16'h0;
    ram[9] = 16'h0909;

    // Reset state
    #1;
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_add", mem_add, 0);
    chk("rst_mem_din", mem_din, 0);
    chk("rst_acks", {a_ack, b_ack}, 0);
    chk("rst_douts", {a_dout, b_dout}, 0);
    chk("rst_busy_gnt", {busy, gnt_b}, 0);
    tick();
    tick();
    rst = 0;
    tick();

    // A write 5 <= BEEF, cycle by cycle
    a_req = 1; a_we = 1; a_add = 6'd5; a_din = 16'hBEEF;
    tick();
    chk("wr_issue_we", mem_we, 1);
    chk("wr_issue_add", mem_add, 5);
    chk("wr_issue_din", mem_din, 16'hBEEF);
    chk("wr_issue_busy_gnt", {busy, gnt_b}, 2'b10);
    tick();
    chk("wr_capt_we", mem_we, 0);
    chk("wr_capt_ack", a_ack, 0);
    tick();
    chk("wr_ack", a_ack, 1);
    a_req = 0;
    tick();
    chk("wr_ack_drop", a_ack, 0);
    chk("wr_idle_busy", busy, 0);

    // A read 5
    do_acc(0, 0, 6'd5, 16'h0, lat, d);
    chk("rd_lat", lat, 3);
    chk("rd_data", d, 16'hBEEF);
    chk("rd_hold", a_dout, 16'hBEEF);

    // Program mode: only B served, A waits
    mode = 0;
    a_req = 1; a_we = 0; a_add = 6'd5;
    b_req = 1; b_we = 0; b_add = 6'd5;
    blat = -1; d = '0; a_seen = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (a_ack) a_seen = 1;
      if (b_ack && blat < 0) begin blat = i; d = b_dout; b_req = 0; end
    end
    chk("pgm_b_lat", blat, 3);
    chk("pgm_b_data", d, 16'hBEEF);
    chk("pgm_a_blocked", a_seen, 0);
    mode = 1;
    alat = -1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (a_ack && alat < 0) begin alat = i; d = a_dout; a_req = 0; end
    end
    chk("run_a_lat", alat, 3);
    chk("run_a_data", d, 16'hBEEF);

    // Starvation: both requesting continuously
    a_req = 1; a_we = 0; a_add = 6'd5;
    b_req = 1; b_we = 0; b_add = 6'd5;
    n = 0; seq = '0; gseq = '0;
    for (int i = 0; i < 60 && n < 10; i++) begin
      tick();
      if (a_ack || b_ack) begin
        seq[n]  = b_ack;
        gseq[n] = gnt_b;
        n++;
        if (n == 10) begin a_req = 0; b_req = 0; end
      end
    end
    tick();
    chk("starve_count", n, 10);
    chk("starve_seq", seq, 10'b1000010000);
    chk("starve_gnt_b", gseq, 10'b1000010000);

    // Simultaneous, counter 0; A holds req through its ack cycle
    a_req = 1; b_req = 1;
    alat = -1; blat = -1; acnt = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (alat > 0 && i == alat + 1) a_req = 0;
      if (a_ack) begin acnt++; if (alat < 0) alat = i; end
      if (b_ack && blat < 0) begin blat = i; b_req = 0; end
    end
    chk("sim_a_lat", alat, 3);
    chk("sim_b_lat", blat, 7);
    chk("sim_a_once", acnt, 1);

    // Reset during ISSUE of a write to 9
    a_req = 1; a_we = 1; a_add = 6'd9; a_din = 16'hDEAD;
    tick();
    chk("rstw_issue_we", mem_we, 1);
    #2 rst = 1;
    #1;
    chk("rstw_mem_we", mem_we, 0);
    chk("rstw_mem_add", mem_add, 0);
    chk("rstw_mem_din", mem_din, 0);
    chk("rstw_busy_gnt", {busy, gnt_b}, 0);
    chk("rstw_douts", {a_dout, b_dout}, 0);
    a_req = 0; a_we = 0;
    tick();
    chk("rstw_no_ack", {a_ack, b_ack}, 0);
    rst = 0;
    tick();
    do_acc(0, 0, 6'd9, 16'h0, lat, d);
    chk("rstw_rd_lat", lat, 3);
    chk("rstw_ram9", d, 16'h0909);

    // Mode drop during CAPT does not abort the access
    a_req = 1; a_we = 0; a_add = 6'd5;
    tick();
    tick();
    mode = 0;
    tick();
    chk("mchg_ack", a_ack, 1);
    chk("mchg_data", a_dout, 16'hBEEF);
    a_req = 0;
    tick();
    a_req = 1;
    a_seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (a_ack || busy) a_seen = 1;
    end
    chk("mchg_a_blocked", a_seen, 0);
    a_req = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
